// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes
// and FSM state encoding.
package alu_muldiv_pkg;

    localparam logic [2:0] MD_MULT = 3'd1;
    localparam logic [2:0] MD_DIV  = 3'd2;
    localparam logic [2:0] MD_MTHI = 3'd3;
    localparam logic [2:0] MD_MTLO = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_t;

endpackage

// File: rtl/alu_muldiv_adder.sv
// Generic ripple adder with carry in/out, shared by the shift-add multiply
// and restoring-divide steps.
module alu_muldiv_adder #(
    parameter int W = 33
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};

endmodule

// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one step per cycle on
// operand magnitudes, followed by a single sign-correction cycle.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter  int N  = 32,
    localparam int CW = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   oper,
    input  logic         sign,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    function automatic logic [N-1:0] neg_n(input logic [N-1:0] v);
        return ~v + N'(1);
    endfunction

    function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] v);
        return ~v + (2*N)'(1);
    endfunction

    md_state_t     state;
    md_state_t     next_state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  mag_a;
    logic [N-1:0]  mag_b;
    logic          neg_res;
    logic          neg_rem;
    logic          op_div;
    logic          b_zero;
    // mul: {partial product, remaining multiplier bits}
    // div: {partial remainder, dividend bits shifting into quotient}
    logic [2*N-1:0] acc;

    logic [N:0]     add_x;
    logic [N:0]     add_y;
    logic           add_cin;
    logic [N:0]     add_sum;
    logic           add_cout;
    logic [2*N-1:0] mul_next;
    logic [2*N-1:0] div_next;
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   quot_fix;
    logic [N-1:0]   rem_fix;

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && oper == MD_MULT) begin
                        next_state = ST_MUL;
                    end else if (start && oper == MD_DIV) begin
                        next_state = ST_DIV;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cnt == CW'(N - 1)) begin
                        next_state = ST_FIX;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Divide: trial subtract of the divisor from the remainder shifted left by
    // one dividend bit; carry-out set means no borrow, so the step succeeds.
    always_comb begin
        if (state == ST_DIV) begin
            add_x   = {acc[2*N-1:N], acc[N-1]};
            add_y   = ~{1'b0, mag_b};
            add_cin = 1'b1;
        end else begin
            add_x   = {1'b0, acc[2*N-1:N]};
            add_y   = {1'b0, mag_a};
            add_cin = 1'b0;
        end
    end

    alu_muldiv_adder #(
        .W(N + 1)
    ) u_adder (
        .x   (add_x),
        .y   (add_y),
        .cin (add_cin),
        .sum (add_sum),
        .cout(add_cout)
    );

    always_comb begin
        mul_next = acc[0] ? {add_sum, acc[N-1:1]} : {1'b0, acc[2*N-1:1]};
        div_next = add_cout ? {add_sum[N-1:0], acc[N-2:0], 1'b1}
                            : {acc[2*N-2:N], acc[N-1], acc[N-2:0], 1'b0};
        prod_fix = neg_res ? neg_2n(acc) : acc;
        quot_fix = neg_res ? neg_n(acc[N-1:0]) : acc[N-1:0];
        rem_fix  = neg_rem ? neg_n(acc[2*N-1:N]) : acc[2*N-1:N];
    end

    // The most negative operand's magnitude 2^(N-1) fits unsigned in N bits,
    // so no extra extension bit is needed for the magnitudes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            op_div   <= 1'b0;
            b_zero   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            if (!abort) begin
                case (state)
                    ST_IDLE: begin
                        if (start && oper == MD_MTHI) begin
                            hi   <= a;
                            done <= 1'b1;
                        end else if (start && oper == MD_MTLO) begin
                            lo   <= a;
                            done <= 1'b1;
                        end else if (start && (oper == MD_MULT || oper == MD_DIV)) begin
                            mag_a   <= (sign && a[N-1]) ? neg_n(a) : a;
                            mag_b   <= (sign && b[N-1]) ? neg_n(b) : b;
                            neg_res <= sign && (a[N-1] ^ b[N-1]);
                            neg_rem <= sign && a[N-1];
                            op_div  <= (oper == MD_DIV);
                            b_zero  <= (b == '0);
                            cnt     <= '0;
                            if (oper == MD_DIV) begin
                                acc <= {{N{1'b0}}, (sign && a[N-1]) ? neg_n(a) : a};
                            end else begin
                                acc <= {{N{1'b0}}, (sign && b[N-1]) ? neg_n(b) : b};
                            end
                        end
                    end
                    ST_MUL: begin
                        acc <= mul_next;
                        cnt <= cnt + CW'(1);
                    end
                    ST_DIV: begin
                        acc <= div_next;
                        cnt <= cnt + CW'(1);
                    end
                    default: begin
                        if (op_div) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end else begin
                            hi <= prod_fix[2*N-1:N];
                            lo <= prod_fix[N-1:0];
                        end
                        done     <= 1'b1;
                        div_zero <= op_div && b_zero;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: cycle-count reference model compared
// every cycle, directed cases from hand-computed values, then random traffic.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   oper;
    logic         sign;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         abort;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    int n_checks = 0;
    int n_fails  = 0;
    logic compare_en = 1'b0;

    always #5 clk = ~clk;

    alu_muldiv #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .oper    (oper),
        .sign    (sign),
        .a       (a),
        .b       (b),
        .abort   (abort),
        .busy    (busy),
        .done    (done),
        .div_zero(div_zero),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: results from plain arithmetic, delivered N+1 cycles later.
    int           remaining = 0;
    logic [N-1:0] m_hi = '0;
    logic [N-1:0] m_lo = '0;
    logic         m_done = 1'b0;
    logic         m_dz = 1'b0;
    logic [N-1:0] r_hi;
    logic [N-1:0] r_lo;
    logic         r_dz;

    task automatic model_compute(input logic [2:0] op, input logic sg, input logic [N-1:0] x,
                                 input logic [N-1:0] y, output logic [N-1:0] rh,
                                 output logic [N-1:0] rl, output logic rdz);
        logic [63:0] p;
        longint      sx, sy, q, r;
        rdz = 1'b0;
        if (op == MD_MULT) begin
            if (sg) p = longint'($signed(x)) * longint'($signed(y));
            else    p = {32'b0, x} * {32'b0, y};
            rh = p[63:32];
            rl = p[31:0];
        end else if (y == '0) begin
            rdz = 1'b1;
            rh  = x;
            rl  = '1;
            if (sg && x[N-1]) rl = -rl;
        end else if (sg) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q  = sx / sy;
            r  = sx % sy;
            rh = r[31:0];
            rl = q[31:0];
        end else begin
            rl = x / y;
            rh = x % y;
        end
    endtask

    always @(posedge clk) begin
        m_done = 1'b0;
        m_dz   = 1'b0;
        if (rst) begin
            remaining = 0;
            m_hi = '0;
            m_lo = '0;
        end else if (abort) begin
            remaining = 0;
        end else if (remaining > 0) begin
            remaining--;
            if (remaining == 0) begin
                m_hi   = r_hi;
                m_lo   = r_lo;
                m_dz   = r_dz;
                m_done = 1'b1;
            end
        end else if (start) begin
            if (oper == MD_MTHI) begin
                m_hi = a;
                m_done = 1'b1;
            end else if (oper == MD_MTLO) begin
                m_lo = a;
                m_done = 1'b1;
            end else if (oper == MD_MULT || oper == MD_DIV) begin
                model_compute(oper, sign, a, b, r_hi, r_lo, r_dz);
                remaining = N + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (compare_en) begin
            check_output("busy", 64'(busy), 64'(remaining > 0));
            check_output("done", 64'(done), 64'(m_done));
            check_output("div_zero", 64'(div_zero), 64'(m_dz));
            check_output("hi", 64'(hi), 64'(m_hi));
            check_output("lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic apply_stimulus(input logic [2:0] op, input logic sg, input logic [N-1:0] x,
                                  input logic [N-1:0] y);
        @(negedge clk);
        start = 1'b1;
        oper  = op;
        sign  = sg;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is high (or after the cycle budget).
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && cycles < 60) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            cycles++;
        end
        check_output("done_within_budget", 64'(done), 64'd1);
    endtask

    task automatic check_lit(input string name, input logic [N-1:0] exp_hi, input logic [N-1:0] exp_lo);
        check_output({name, "_hi"}, 64'(hi), 64'(exp_hi));
        check_output({name, "_lo"}, 64'(lo), 64'(exp_lo));
        check_output({name, "_model_hi"}, 64'(m_hi), 64'(exp_hi));
        check_output({name, "_model_lo"}, 64'(m_lo), 64'(exp_lo));
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic sg,
                          input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic [N-1:0] exp_hi, input logic [N-1:0] exp_lo);
        int cyc, bcyc;
        apply_stimulus(op, sg, x, y);
        wait_done(cyc, bcyc);
        check_lit(name, exp_hi, exp_lo);
    endtask

    function automatic logic [N-1:0] pick_val();
        logic [N-1:0] specials [5];
        specials[0] = '0;
        specials[1] = 32'd1;
        specials[2] = '1;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;
        if ($urandom_range(3) == 0) return specials[$urandom_range(4)];
        return $urandom;
    endfunction

    initial begin
        int cyc, bcyc;
        rst = 1'b1; start = 1'b0; oper = '0; sign = 1'b0; a = '0; b = '0; abort = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_en = 1'b1;
        check_lit("reset", '0, '0);
        check_output("reset_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        apply_stimulus(MD_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc, bcyc);
        check_output("multu_latency", 64'(cyc), 64'(N + 1));
        check_output("multu_busy_cycles", 64'(bcyc), 64'(N + 1));
        check_lit("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

        run_op("mult_neg3x7", MD_MULT, 1'b1, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_minxmin", MD_MULT, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        run_op("div_neg7by2", MD_DIV, 1'b1, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_overflow", MD_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("divu_100by7", MD_DIV, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);

        apply_stimulus(MD_DIV, 1'b0, 32'h1234, 32'h0);
        wait_done(cyc, bcyc);
        check_output("divu_zero_flag", 64'(div_zero), 64'd1);
        check_lit("divu_zero", 32'h1234, 32'hFFFF_FFFF);

        // Abort sampled at start+10 together with a fresh start request.
        apply_stimulus(MD_MULT, 1'b0, 32'd5, 32'd9);
        repeat (9) @(negedge clk);
        abort = 1'b1; start = 1'b1; oper = MD_MULT; a = 32'd3; b = 32'd3;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check_output("abort_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check_output("abort_no_done", 64'(done), 64'd0);
        end
        check_lit("abort_keep", 32'h1234, 32'hFFFF_FFFF);

        // Reset sampled at start+5.
        apply_stimulus(MD_DIV, 1'b1, 32'd1000, 32'd3);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        check_lit("rst_mid", '0, '0);

        // Back-to-back moves.
        @(negedge clk);
        start = 1'b1; oper = MD_MTHI; a = 32'hA5;
        @(negedge clk);
        check_output("mthi_done", 64'(done), 64'd1);
        check_output("mthi_hi", 64'(hi), 64'hA5);
        oper = MD_MTLO; a = 32'h5A;
        @(negedge clk);
        start = 1'b0;
        check_output("mtlo_done", 64'(done), 64'd1);
        check_lit("moves", 32'hA5, 32'h5A);

        // New MULTU presented in the done cycle of a prior operation.
        apply_stimulus(MD_MULT, 1'b0, 32'd6, 32'd7);
        wait_done(cyc, bcyc);
        check_lit("mul6x7", 32'd0, 32'd42);
        start = 1'b1; oper = MD_MULT; sign = 1'b0; a = 32'd11; b = 32'd13;
        @(negedge clk);
        start = 1'b0;
        check_output("done_cycle_accept", 64'(busy), 64'd1);
        wait_done(cyc, bcyc);
        check_lit("mul11x13", 32'd0, 32'd143);

        // Random traffic, including starts while busy, aborts and resets.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start = ($urandom_range(2) == 0);
            case ($urandom_range(5))
                0, 4:    oper = MD_MULT;
                1, 5:    oper = MD_DIV;
                2:       oper = ($urandom_range(1) == 0) ? MD_MTHI : MD_MTLO;
                default: oper = 3'($urandom_range(7));
            endcase
            sign  = 1'($urandom_range(1));
            a     = pick_val();
            b     = pick_val();
            abort = ($urandom_range(59) == 0);
            rst   = ($urandom_range(699) == 0);
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        repeat (N + 3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
